mpd_io_cfg_loader: RTL and testbench

//  Loads per-pad fabric IO configuration words and signals completion to the pad controllers.

---
 rtl/mpd_io_cfg_loader_pkg.sv | 22 ++
 rtl/mpd_io_cfg_loader.sv | 107 ++++++++++
 tb/tb_mpd_io_cfg_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mpd_io_cfg_loader_pkg.sv
// Shared definitions for the fabric IO configuration loader and the pad
// controllers it feeds.
//   - MPD_CFG_W        : width of one per-pad configuration word
//   - mpd_state_t      : loader FSM states (IDLE=0, LOAD=1, DONE=2)
//   - MPD_CFG_*        : bit-field offsets inside a configuration word,
//                        shared with the pad controller decode
package mpd_io_cfg_loader_pkg;

    localparam int unsigned MPD_CFG_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } mpd_state_t;

    // Configuration word bit map: out value at the top, drive mode at the bottom.
    localparam int unsigned MPD_CFG_OUT_VAL_BIT = 11;
    localparam int unsigned MPD_CFG_DM_LSB      = 0;
    localparam int unsigned MPD_CFG_DM_W        = 3;

endpackage : mpd_io_cfg_loader_pkg

// File: rtl/mpd_io_cfg_loader.sv
// Loads per-pad fabric IO configuration words and flags completion to the
// pad controllers. Words arrive over a valid/ready handshake in pad order
// 0..NUM_IO-1; each is stored in that pad's register, which drives the
// pad's slice of fabric_config. fabric_done rises once every pad has a word.
//
// Ports
//   clk            single clock
//   resetn         asynchronous active-low reset
//   start          pulse: begin or restart a load sequence (priority over accept)
//   word_valid     word_data valid this cycle
//   word_data      configuration word for pad io_index
//   word_ready     word accepted this cycle if valid (decoded from state and start)
//   io_index       pad index the next accepted word is written to
//   busy           high while loading
//   fabric_done    all NUM_IO words loaded
//   fabric_config  slice [i*CFG_W +: CFG_W] drives pad i
//   err_overrun    sticky: word_valid seen while DONE, cleared by start
module mpd_io_cfg_loader
    import mpd_io_cfg_loader_pkg::*;
#(
    parameter int unsigned NUM_IO = 38,
    parameter int unsigned CFG_W  = MPD_CFG_W,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    word_valid,
    input  logic [CFG_W-1:0]        word_data,
    output logic                    word_ready,
    output logic [IDX_W-1:0]        io_index,
    output logic                    busy,
    output logic                    fabric_done,
    output logic [NUM_IO*CFG_W-1:0] fabric_config,
    output logic                    err_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IO - 1);

    mpd_state_t state;
    logic       accept;
    logic       last_word;

    // start wins over an incoming word, so ready is masked in the start cycle.
    always_comb begin
        word_ready = (state == ST_LOAD) && !start;
        accept     = word_valid && word_ready;
        last_word  = (io_index == LAST_IDX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            io_index    <= '0;
            busy        <= 1'b0;
            fabric_done <= 1'b0;
            err_overrun <= 1'b0;
        end else if (start) begin
            state       <= ST_LOAD;
            io_index    <= '0;
            busy        <= 1'b1;
            fabric_done <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            state       <= ST_DONE;
                            io_index    <= '0;
                            busy        <= 1'b0;
                            fabric_done <= 1'b1;
                        end else begin
                            io_index <= io_index + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (word_valid) begin
                        err_overrun <= 1'b1;
                    end
                end
                default: begin
                    // IDLE: words are ignored without flagging an error.
                end
            endcase
        end
    end

    // One register per pad; old contents persist across a restart until
    // overwritten, which is harmless because pads ignore them while
    // fabric_done is low.
    for (genvar g = 0; g < NUM_IO; g++) begin : g_pad
        logic [CFG_W-1:0] cfg_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cfg_q <= '0;
            end else if (accept && (io_index == IDX_W'(g))) begin
                cfg_q <= word_data;
            end
        end

        assign fabric_config[g*CFG_W +: CFG_W] = cfg_q;
    end

endmodule : mpd_io_cfg_loader

// File: tb/tb_mpd_io_cfg_loader.sv
module tb_mpd_io_cfg_loader;

    localparam int NUM_IO = 38;
    localparam int CFG_W  = 12;
    localparam int IDX_W  = 6;

    logic                    clk;
    logic                    resetn;
    logic                    start;
    logic                    word_valid;
    logic [CFG_W-1:0]        word_data;
    logic                    word_ready;
    logic [IDX_W-1:0]        io_index;
    logic                    busy;
    logic                    fabric_done;
    logic [NUM_IO*CFG_W-1:0] fabric_config;
    logic                    err_overrun;

    logic [CFG_W-1:0] exp_cfg [NUM_IO];
    int errors = 0;
    int checks = 0;

    mpd_io_cfg_loader #(
        .NUM_IO (NUM_IO),
        .CFG_W  (CFG_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_ready    (word_ready),
        .io_index      (io_index),
        .busy          (busy),
        .fabric_done   (fabric_done),
        .fabric_config (fabric_config),
        .err_overrun   (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slices(input string tag);
        for (int i = 0; i < NUM_IO; i++)
            check($sformatf("%s_slice%0d", tag, i), 64'(fabric_config[i*CFG_W +: CFG_W]), 64'(exp_cfg[i]));
    endtask

    // Pulse start for one cycle; the loader must be in LOAD at index 0 afterwards.
    task automatic do_start(input string tag);
        start = 1'b1;
        #0;
        check({tag, "_ready_in_start"}, 64'(word_ready), 64'd0);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_idx0"}, 64'(io_index), 64'd0);
        check({tag, "_done0"}, 64'(fabric_done), 64'd0);
    endtask

    // Back-to-back words for pads first..first+n-1.
    task automatic load_words(input string tag, input int first, input int n,
                              input bit fixed, input logic [CFG_W-1:0] val, input int base);
        for (int i = first; i < first + n; i++) begin
            word_valid = 1'b1;
            word_data  = fixed ? val : CFG_W'(i + base);
            #0;
            check($sformatf("%s_ready%0d", tag, i), 64'(word_ready), 64'd1);
            check($sformatf("%s_idx%0d", tag, i), 64'(io_index), 64'(i));
            check($sformatf("%s_done_low%0d", tag, i), 64'(fabric_done), 64'd0);
            exp_cfg[i] = word_data;
            tick();
        end
        word_valid = 1'b0;
        word_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        resetn     = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        for (int i = 0; i < NUM_IO; i++) exp_cfg[i] = '0;

        // Reset state
        tick();
        tick();
        check("rst_idx", 64'(io_index), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(fabric_done), 64'd0);
        check("rst_err", 64'(err_overrun), 64'd0);
        check("rst_ready", 64'(word_ready), 64'd0);
        check("rst_cfg", 64'(fabric_config == '0), 64'd1);
        resetn = 1'b1;
        tick();

        // IDLE ignores words without an error
        word_valid = 1'b1;
        word_data  = 12'h5A5;
        #0;
        check("idle_ready", 64'(word_ready), 64'd0);
        tick();
        word_valid = 1'b0;
        check("idle_err", 64'(err_overrun), 64'd0);
        check("idle_idx", 64'(io_index), 64'd0);
        check("idle_cfg", 64'(fabric_config == '0), 64'd1);

        // Test 1: 38 back-to-back words, data = pad index
        do_start("t1");
        load_words("t1", 0, NUM_IO, 1'b0, '0, 0);
        check("t1_done", 64'(fabric_done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_idx_wrap", 64'(io_index), 64'd0);
        check("t1_ready_done", 64'(word_ready), 64'd0);
        check_slices("t1");

        // Test 2: valid only every third cycle; index advances only on accept
        do_start("t2");
        n = 0;
        c = 0;
        while (n < NUM_IO && c < 300) begin
            word_valid = (c % 3 == 2);
            word_data  = CFG_W'(n);
            #0;
            check($sformatf("t2_idx_c%0d", c), 64'(io_index), 64'(n));
            if (word_valid) begin
                exp_cfg[n] = word_data;
                n++;
            end
            tick();
            c++;
        end
        word_valid = 1'b0;
        check("t2_count", 64'(n), 64'(NUM_IO));
        check("t2_done", 64'(fabric_done), 64'd1);
        check_slices("t2");

        // Test 3: restart with a valid word pending at index 20
        do_start("t3");
        load_words("t3", 0, 20, 1'b0, '0, 100);
        check("t3_idx20", 64'(io_index), 64'd20);
        start      = 1'b1;
        word_valid = 1'b1;
        word_data  = 12'hABC;
        #0;
        check("t3_ready_blocked", 64'(word_ready), 64'd0);
        tick();
        start      = 1'b0;
        word_valid = 1'b0;
        check("t3_idx_restart", 64'(io_index), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_slice20_old", 64'(fabric_config[20*CFG_W +: CFG_W]), 64'd20);
        check_slices("t3");

        // Test 4: overrun in DONE is sticky until the next start
        load_words("t4", 0, NUM_IO, 1'b0, '0, 0);
        check("t4_done", 64'(fabric_done), 64'd1);
        word_valid = 1'b1;
        word_data  = 12'h777;
        tick();
        word_valid = 1'b0;
        check("t4_err_set", 64'(err_overrun), 64'd1);
        tick();
        tick();
        tick();
        check("t4_err_sticky", 64'(err_overrun), 64'd1);
        check("t4_done_held", 64'(fabric_done), 64'd1);
        check_slices("t4");
        do_start("t4r");
        check("t4_err_cleared", 64'(err_overrun), 64'd0);

        // Test 5: asynchronous reset mid-load at index 10
        load_words("t5", 0, 10, 1'b0, '0, 200);
        check("t5_idx10", 64'(io_index), 64'd10);
        #2;
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NUM_IO; i++) exp_cfg[i] = '0;
        check("t5_async_idx", 64'(io_index), 64'd0);
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_done", 64'(fabric_done), 64'd0);
        check("t5_async_cfg", 64'(fabric_config == '0), 64'd1);
        start      = 1'b1;
        word_valid = 1'b1;
        tick();
        tick();
        check("t5_held_idx", 64'(io_index), 64'd0);
        check("t5_held_busy", 64'(busy), 64'd0);
        check("t5_held_ready", 64'(word_ready), 64'd0);
        check("t5_held_cfg", 64'(fabric_config == '0), 64'd1);
        start      = 1'b0;
        word_valid = 1'b0;
        resetn     = 1'b1;
        tick();
        check("t5_post_idx", 64'(io_index), 64'd0);
        check("t5_post_busy", 64'(busy), 64'd0);

        // Test 6: all-ones load, then all-zeros reload with done low throughout
        do_start("t6a");
        load_words("t6a", 0, NUM_IO, 1'b1, 12'hFFF, 0);
        check("t6a_done", 64'(fabric_done), 64'd1);
        check_slices("t6a");
        do_start("t6b");
        load_words("t6b", 0, NUM_IO, 1'b1, 12'h000, 0);
        check("t6b_done", 64'(fabric_done), 64'd1);
        check("t6b_all_zero", 64'(fabric_config == '0), 64'd1);
        check_slices("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mpd_io_cfg_loader
